// File: rtl/mem_access_pkg.sv
// Shared encodings, FSM states and lane helpers for the data-memory initiator.
// Pure declarations and combinational functions; no latency, no backpressure.
package mem_access_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2,
      ST_RESP = 2'd3
   } state_t;

   typedef struct packed {
      logic        write;
      logic [1:0]  size;
      logic        sgn;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   function automatic logic req_is_error(input logic [1:0]  size,
                                         input logic [31:0] addr,
                                         input int unsigned words);
      logic bad_align;
      case (size)
         SZ_BYTE: bad_align = 1'b0;
         SZ_HALF: bad_align = addr[0];
         SZ_WORD: bad_align = |addr[1:0];
         default: bad_align = 1'b1;
      endcase
      return bad_align || ({2'b00, addr[31:2]} >= words);
   endfunction

   function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane);
      logic [31:0] r;
      r = word;
      case (size)
         SZ_BYTE: begin
            case (lane)
               2'd0:    r[7:0]   = wdata[7:0];
               2'd1:    r[15:8]  = wdata[7:0];
               2'd2:    r[23:16] = wdata[7:0];
               default: r[31:24] = wdata[7:0];
            endcase
         end
         SZ_HALF: begin
            if (lane[1]) r[31:16] = wdata[15:0];
            else         r[15:0]  = wdata[15:0];
         end
         default: r = wdata;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] lane_extend(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lane,
                                               input logic        sgn);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (lane)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      h = lane[1] ? word[31:16] : word[15:0];
      case (size)
         SZ_BYTE: r = {{24{sgn & b[7]}}, b};
         SZ_HALF: r = {{16{sgn & h[15]}}, h};
         default: r = word;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// Lane steering: merges a store lane into a read word and extracts/extends a load lane.
// Latency: combinational; backpressure: none (pure datapath).
module mem_byte_lane
   import mem_access_pkg::*;
(
   input  logic [31:0] word,
   input  logic [31:0] wdata,
   input  logic [1:0]  size,
   input  logic [1:0]  lane,
   input  logic        sgn,
   output logic [31:0] merged,
   output logic [31:0] loaded
);

   assign merged = lane_merge(word, wdata, size, lane);
   assign loaded = lane_extend(word, size, lane, sgn);

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store initiator with read-modify-write for sub-word stores.
// Latency: error 1, load/word store 2, sub-word store 3 cycles; response held until resp_ready.
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int unsigned MEM_WORDS = 128
) (
   input  logic        clock_in,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_error,
   output logic [31:0] address,
   output logic        memRead,
   output logic        memWrite,
   output logic [31:0] writeData,
   input  logic [31:0] readData
);

   state_t      state, state_nxt;
   req_t        req_q, req_in, cur;
   logic        accept, req_err;
   logic [31:0] lane_merged, lane_loaded;

   logic        req_ready_nxt, resp_valid_nxt, resp_error_nxt;
   logic        mem_read_nxt, mem_write_nxt;
   logic [31:0] resp_rdata_nxt, address_nxt, write_data_nxt;

   always_comb begin
      req_in.write = req_write;
      req_in.size  = req_size;
      req_in.sgn   = req_signed;
      req_in.addr  = req_addr;
      req_in.wdata = req_wdata;
   end

   // Registered outputs are computed on the transition edge, so the live request
   // is used while leaving IDLE and the latched copy everywhere else.
   assign cur     = (state == ST_IDLE) ? req_in : req_q;
   assign accept  = req_valid && req_ready;
   assign req_err = req_is_error(req_size, req_addr, MEM_WORDS);

   mem_byte_lane u_lane (
      .word   (readData),
      .wdata  (req_q.wdata),
      .size   (req_q.size),
      .lane   (req_q.addr[1:0]),
      .sgn    (req_q.sgn),
      .merged (lane_merged),
      .loaded (lane_loaded)
   );

   always_ff @(posedge clock_in) begin
      if (reset) begin
         state      <= ST_IDLE;
         req_q      <= '0;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_error <= 1'b0;
         address    <= '0;
         memRead    <= 1'b0;
         memWrite   <= 1'b0;
         writeData  <= '0;
      end else begin
         state      <= state_nxt;
         if (accept) req_q <= req_in;
         req_ready  <= req_ready_nxt;
         resp_valid <= resp_valid_nxt;
         resp_rdata <= resp_rdata_nxt;
         resp_error <= resp_error_nxt;
         address    <= address_nxt;
         memRead    <= mem_read_nxt;
         memWrite   <= mem_write_nxt;
         writeData  <= write_data_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               if (req_err)                  state_nxt = ST_RESP;
               else if (!req_write)          state_nxt = ST_RD;
               else if (req_size == SZ_WORD) state_nxt = ST_WR;
               else                          state_nxt = ST_RD;
            end
         end
         ST_RD:   state_nxt = req_q.write ? ST_WR : ST_RESP;
         ST_WR:   state_nxt = ST_RESP;
         ST_RESP: if (resp_ready) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      req_ready_nxt  = (state_nxt == ST_IDLE);
      mem_read_nxt   = (state_nxt == ST_RD);
      mem_write_nxt  = (state_nxt == ST_WR);
      resp_valid_nxt = (state_nxt == ST_RESP);
      address_nxt    = '0;
      write_data_nxt = '0;
      resp_rdata_nxt = '0;
      resp_error_nxt = 1'b0;
      if (state_nxt == ST_RD || state_nxt == ST_WR)
         address_nxt = {cur.addr[31:2], 2'b00};
      // Sub-word stores only reach WR from RD, where readData holds the word to merge into.
      if (state_nxt == ST_WR)
         write_data_nxt = (cur.size == SZ_WORD) ? cur.wdata : lane_merged;
      if (state == ST_RESP) begin
         if (state_nxt == ST_RESP) begin
            resp_rdata_nxt = resp_rdata;
            resp_error_nxt = resp_error;
         end
      end else if (state_nxt == ST_RESP) begin
         resp_error_nxt = (state == ST_IDLE);
         resp_rdata_nxt = (state == ST_RD) ? lane_loaded : '0;
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit against a 128-word behavioural data memory.
module tb_mem_access_unit;
   import mem_access_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_write, req_signed;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_ready, resp_error;
   logic [31:0] resp_rdata;
   logic [31:0] address, writeData, readData;
   logic        memRead, memWrite;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mem_access_unit #(.MEM_WORDS(128)) dut (
      .clock_in   (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_error (resp_error),
      .address    (address),
      .memRead    (memRead),
      .memWrite   (memWrite),
      .writeData  (writeData),
      .readData   (readData)
   );

   // Behavioural data memory plus bus monitors.
   logic [31:0] mem [128];
   logic        mem_clr;
   int          rd_cnt = 0;
   int          wr_cnt = 0;
   logic        both_viol = 1'b0;
   logic        align_viol = 1'b0;

   assign readData = mem[address[8:2]];

   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 128; i++) mem[i] <= '0;
      end else if (memWrite) begin
         mem[address[8:2]] <= writeData;
      end
      if (memRead)  rd_cnt <= rd_cnt + 1;
      if (memWrite) wr_cnt <= wr_cnt + 1;
      if (memRead && memWrite) both_viol <= 1'b1;
      if ((memRead || memWrite) && address[1:0] != 2'b00) align_viol <= 1'b1;
   end

   typedef struct {
      logic        write;
      logic [1:0]  size;
      logic        sgn;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
      int          exp_rd;
      int          exp_wr;
   } vec_t;

   localparam int NV = 19;
   vec_t vecs [NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive_req(input vec_t v);
      req_valid  = 1'b1;
      req_write  = v.write;
      req_size   = v.size;
      req_signed = v.sgn;
      req_addr   = v.addr;
      req_wdata  = v.wdata;
   endtask

   // After the accept edge the request pins are scrambled to expose any use of live inputs.
   task automatic scramble(input vec_t v);
      req_valid  = 1'b0;
      req_write  = ~v.write;
      req_size   = ~v.size;
      req_signed = ~v.sgn;
      req_addr   = ~v.addr;
      req_wdata  = ~v.wdata;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) chk({name, "_ready_timeout"}, {31'd0, req_ready}, 32'd1);
   endtask

   task automatic run_vec(input vec_t v, input string name);
      int lat, rd0, wr0;
      wait_idle(name);
      drive_req(v);
      rd0 = rd_cnt;
      wr0 = wr_cnt;
      @(posedge clk);
      #1 scramble(v);
      lat = 0;
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk);
         if (resp_valid) begin
            lat = n;
            break;
         end
      end
      chk({name, "_lat"}, lat, v.exp_lat);
      if (lat != 0) begin
         chk({name, "_rdata"}, resp_rdata, v.exp_rdata);
         chk({name, "_err"}, {31'd0, resp_error}, {31'd0, v.exp_err});
         chk({name, "_rd_cnt"}, rd_cnt - rd0, v.exp_rd);
         chk({name, "_wr_cnt"}, wr_cnt - wr0, v.exp_wr);
      end
   endtask

   task automatic chk_reset_outputs(input string name);
      chk({name, "_req_ready"},  {31'd0, req_ready},  32'd1);
      chk({name, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
      chk({name, "_resp_rdata"}, resp_rdata,          32'd0);
      chk({name, "_resp_error"}, {31'd0, resp_error}, 32'd0);
      chk({name, "_address"},    address,             32'd0);
      chk({name, "_memRead"},    {31'd0, memRead},    32'd0);
      chk({name, "_memWrite"},   {31'd0, memWrite},   32'd0);
      chk({name, "_writeData"},  writeData,           32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      vec_t v;
      int   wr0;

      //        wr    size     sgn   addr        wdata          rdata          err  lat rd wr
      vecs[0]  = '{1'b1, SZ_WORD, 1'b0, 32'h10,  32'hDEADBEEF, 32'h00000000, 1'b0, 2, 0, 1};
      vecs[1]  = '{1'b0, SZ_WORD, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 2, 1, 0};
      vecs[2]  = '{1'b1, SZ_WORD, 1'b0, 32'h10,  32'h11223344, 32'h00000000, 1'b0, 2, 0, 1};
      vecs[3]  = '{1'b1, SZ_BYTE, 1'b0, 32'h12,  32'h000000AA, 32'h00000000, 1'b0, 3, 1, 1};
      vecs[4]  = '{1'b0, SZ_WORD, 1'b0, 32'h10,  32'h0,        32'h11AA3344, 1'b0, 2, 1, 0};
      vecs[5]  = '{1'b1, SZ_WORD, 1'b0, 32'h14,  32'h000080F0, 32'h00000000, 1'b0, 2, 0, 1};
      vecs[6]  = '{1'b0, SZ_BYTE, 1'b1, 32'h14,  32'h0,        32'hFFFFFFF0, 1'b0, 2, 1, 0};
      vecs[7]  = '{1'b0, SZ_HALF, 1'b0, 32'h14,  32'h0,        32'h000080F0, 1'b0, 2, 1, 0};
      vecs[8]  = '{1'b0, SZ_HALF, 1'b1, 32'h14,  32'h0,        32'hFFFF80F0, 1'b0, 2, 1, 0};
      vecs[9]  = '{1'b0, SZ_HALF, 1'b0, 32'h13,  32'h0,        32'h00000000, 1'b1, 1, 0, 0};
      vecs[10] = '{1'b1, SZ_WORD, 1'b0, 32'h06,  32'h12345678, 32'h00000000, 1'b1, 1, 0, 0};
      vecs[11] = '{1'b0, SZ_WORD, 1'b0, 32'h200, 32'h0,        32'h00000000, 1'b1, 1, 0, 0};
      vecs[12] = '{1'b0, SZ_ILL,  1'b0, 32'h20,  32'h0,        32'h00000000, 1'b1, 1, 0, 0};
      vecs[13] = '{1'b1, SZ_HALF, 1'b0, 32'h16,  32'h1234BEEF, 32'h00000000, 1'b0, 3, 1, 1};
      vecs[14] = '{1'b0, SZ_WORD, 1'b0, 32'h14,  32'h0,        32'hBEEF80F0, 1'b0, 2, 1, 0};
      vecs[15] = '{1'b0, SZ_BYTE, 1'b0, 32'h17,  32'h0,        32'h000000BE, 1'b0, 2, 1, 0};
      vecs[16] = '{1'b0, SZ_BYTE, 1'b1, 32'h17,  32'h0,        32'hFFFFFFBE, 1'b0, 2, 1, 0};
      vecs[17] = '{1'b1, SZ_BYTE, 1'b0, 32'h10,  32'hFFFFFF55, 32'h00000000, 1'b0, 3, 1, 1};
      vecs[18] = '{1'b0, SZ_HALF, 1'b0, 32'h12,  32'h0,        32'h000011AA, 1'b0, 2, 1, 0};

      reset      = 1'b1;
      mem_clr    = 1'b1;
      resp_ready = 1'b1;
      v = '{1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 0, 0, 0};
      scramble(v);
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset   = 1'b0;
      mem_clr = 1'b0;
      chk_reset_outputs("reset");

      for (int i = 0; i < NV; i++) run_vec(vecs[i], $sformatf("v%0d", i));

      // Last in-range word (index 127) was never written.
      v = '{1'b0, SZ_WORD, 1'b0, 32'h1FC, 32'h0, 32'h0, 1'b0, 2, 1, 0};
      run_vec(v, "last_word");

      // Consumer stalls for 5 cycles: response must hold, no new request accepted.
      wait_idle("stall");
      v = '{1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h11AA3355, 1'b0, 2, 1, 0};
      resp_ready = 1'b0;
      drive_req(v);
      @(posedge clk);
      #1 scramble(v);
      req_valid = 1'b1;
      @(negedge clk);
      @(negedge clk);
      for (int c = 0; c < 5; c++) begin
         chk($sformatf("stall%0d_valid", c), {31'd0, resp_valid}, 32'd1);
         chk($sformatf("stall%0d_rdata", c), resp_rdata, 32'h11AA3355);
         chk($sformatf("stall%0d_req_ready", c), {31'd0, req_ready}, 32'd0);
         @(negedge clk);
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      @(negedge clk);
      chk("stall_release_valid", {31'd0, resp_valid}, 32'd0);
      chk("stall_release_ready", {31'd0, req_ready}, 32'd1);
      chk("stall_release_rdata", resp_rdata, 32'd0);

      // Reset lands while a byte store is reading: no write, clean state.
      wait_idle("rst_rd");
      v = '{1'b1, SZ_BYTE, 1'b0, 32'h11, 32'h000000CC, 32'h0, 1'b0, 0, 0, 0};
      drive_req(v);
      wr0 = wr_cnt;
      @(posedge clk);
      #1 scramble(v);
      @(negedge clk);
      chk("rst_rd_in_rd", {31'd0, memRead}, 32'd1);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk_reset_outputs("rst_rd");
      chk("rst_rd_no_write", wr_cnt - wr0, 32'd0);
      @(negedge clk);
      chk("rst_rd_no_resp", {31'd0, resp_valid}, 32'd0);
      v = '{1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h11AA3355, 1'b0, 2, 1, 0};
      run_vec(v, "rst_rd_after");

      // Reset lands while the write strobe is high: strobe lasts exactly one cycle.
      wait_idle("rst_wr");
      v = '{1'b1, SZ_WORD, 1'b0, 32'h18, 32'hCAFEF00D, 32'h0, 1'b0, 0, 0, 0};
      drive_req(v);
      wr0 = wr_cnt;
      @(posedge clk);
      #1 scramble(v);
      @(negedge clk);
      chk("rst_wr_in_wr", {31'd0, memWrite}, 32'd1);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk_reset_outputs("rst_wr");
      @(negedge clk);
      chk("rst_wr_one_strobe", wr_cnt - wr0, 32'd1);
      chk("rst_wr_no_resp", {31'd0, resp_valid}, 32'd0);
      v = '{1'b0, SZ_WORD, 1'b0, 32'h18, 32'h0, 32'hCAFEF00D, 1'b0, 2, 1, 0};
      run_vec(v, "rst_wr_after");

      @(negedge clk);
      chk("no_rd_wr_overlap", {31'd0, both_viol}, 32'd0);
      chk("addr_aligned", {31'd0, align_viol}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
